// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a parallel word over valid/ready, frames it with
// start/optional parity/stop bits and shifts it out LSB first on txd.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD       = 1'(PARITY_ODD);

    logic [2:0]           state;
    logic [CW-1:0]        baud;
    logic [3:0]           bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;

    logic bit_end;
    assign bit_end = (baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud     <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state != S_IDLE)
                baud <= bit_end ? '0 : baud + 1'b1;
            // tx_done is registered, so it is raised one cycle ahead of the final boundary
            if (state == S_STOP && bitcnt == STOP_LAST && baud == BAUD_PRE)
                tx_done <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        state    <= S_START;
                        baud     <= '0;
                        bitcnt   <= '0;
                        shreg    <= tx_data;
                        par      <= (^tx_data) ^ ODD;
                        txd      <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state  <= S_DATA;
                        bitcnt <= '0;
                        txd    <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bitcnt == DATA_LAST) begin
                            bitcnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= S_PARITY;
                                txd   <= par;
                            end else begin
                                state <= S_STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            txd    <= shreg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state  <= S_STOP;
                        bitcnt <= '0;
                        txd    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (bitcnt == STOP_LAST) begin
                            state    <= S_IDLE;
                            bitcnt   <= '0;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    baud     <= '0;
                    bitcnt   <= '0;
                    txd      <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four configurations checked every cycle against a frame-level
// model, plus hand-computed literal expectations for each directed scenario.
module tb_uart_tx_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] valid_v = '0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic [6:0] d3 = '0;
    logic [3:0] ready_v, txd_v, busy_v, done_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
        .txd(txd_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
        .txd(txd_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
        .txd(txd_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx_ctrl #(.CLKS_PER_BIT(2), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data(d3), .tx_valid(valid_v[3]), .tx_ready(ready_v[3]),
        .txd(txd_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    function automatic int cpb_of(int id);  return (id == 3) ? 2 : 4;            endfunction
    function automatic int db_of(int id);   return (id == 3) ? 7 : 8;            endfunction
    function automatic int pe_of(int id);   return (id == 1 || id == 2) ? 1 : 0; endfunction
    function automatic int po_of(int id);   return (id == 2) ? 1 : 0;            endfunction
    function automatic int sb_of(int id);   return (id == 3) ? 2 : 1;            endfunction
    function automatic int nbits_of(int id);
        return 1 + db_of(id) + pe_of(id) + sb_of(id);
    endfunction
    function automatic int flen_of(int id);
        return cpb_of(id) * nbits_of(id);
    endfunction

    function automatic logic [8:0] data_of(int id);
        case (id)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            2:       return {1'b0, d2};
            default: return {2'b00, d3};
        endcase
    endfunction

    // Bit sequence on the line for one word: start, data LSB first, parity, stops.
    function automatic logic [15:0] build_frame(int id, logic [8:0] w);
        logic [15:0] b = '0;
        int n = 1;
        int ones = 0;
        for (int i = 0; i < db_of(id); i++) begin
            b[n] = w[i];
            if (w[i]) ones++;
            n++;
        end
        if (pe_of(id) != 0) begin
            b[n] = ((ones + po_of(id)) % 2) != 0;
            n++;
        end
        for (int s = 0; s < sb_of(id); s++) begin
            b[n] = 1'b1;
            n++;
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_data(input int id, input logic [8:0] w);
        case (id)
            0:       d0 = w[7:0];
            1:       d1 = w[7:0];
            2:       d2 = w[7:0];
            default: d3 = w[6:0];
        endcase
    endtask

    // Model: m_k counts cycles since the accept edge (cycle 1 = first start-bit cycle).
    bit          m_busy [4];
    int          m_k    [4];
    logic [15:0] m_frame[4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_busy[i]) begin
                    m_k[i]++;
                    if (m_k[i] > flen_of(i)) m_busy[i] = 1'b0;
                end else if (valid_v[i]) begin
                    m_busy[i]  = 1'b1;
                    m_k[i]     = 1;
                    m_frame[i] = build_frame(i, data_of(i));
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            logic et, er, ed;
            int   idx;
            if (!rst_n || !m_busy[i]) begin
                et = 1'b1; er = 1'b1; ed = 1'b0;
            end else begin
                idx = (m_k[i] - 1) / cpb_of(i);
                et  = m_frame[i][idx];
                er  = 1'b0;
                ed  = (m_k[i] == flen_of(i));
            end
            check($sformatf("u%0d_txd_rdy_busy_done", i),
                  {28'd0, txd_v[i], ready_v[i], busy_v[i], done_v[i]},
                  {28'd0, et, er, ~er, ed});
        end
    end

    // Sends one word and samples the middle of each bit period, the tx_done cycle and
    // the first cycle tx_ready is back. poke>0 pulses tx_valid with new data mid-frame.
    task automatic run_frame(input int id, input logic [8:0] w, input int poke,
                             output logic [15:0] bits, output int dc, output int rc);
        int cpb = cpb_of(id);
        int nb  = nbits_of(id);
        bits = '0; dc = -1; rc = -1;
        @(negedge clk);
        set_data(id, w);
        valid_v[id] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_v[id] = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c == poke) begin
                set_data(id, '0);
                valid_v[id] = 1'b1;
            end else if (poke > 0 && c == poke + 1) begin
                valid_v[id] = 1'b0;
            end
            if ((c - 1) % cpb == cpb / 2 && (c - 1) / cpb < nb)
                bits[(c - 1) / cpb] = txd_v[id];
            if (done_v[id] && dc < 0) dc = c;
            if (ready_v[id]) begin
                rc = c;
                break;
            end
            @(negedge clk);
        end
        valid_v[id] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] bits;
        int dc, rc, start2;

        repeat (3) @(negedge clk);
        check("reset_state", {16'd0, txd_v, ready_v, busy_v, done_v}, {16'd0, 4'hF, 4'hF, 4'h0, 4'h0});
        #1 rst_n = 1'b1;

        // 8N1 0xA5: bits 0,1,0,1,0,0,1,0,1,1 (index 0 first)
        run_frame(0, 9'h0A5, 0, bits, dc, rc);
        check("a5_bits",  {22'd0, bits[9:0]}, 32'h34A);
        check("a5_done",  dc, 40);
        check("a5_ready", rc, 41);

        // 8E1 0x07: three ones -> even parity bit 1
        run_frame(1, 9'h007, 0, bits, dc, rc);
        check("e07_parity", {31'd0, bits[9]}, 32'd1);
        check("e07_bits",   {21'd0, bits[10:0]}, 32'h60E);
        check("e07_done",   dc, 44);

        // 8O1 0x07: odd parity bit 0
        run_frame(2, 9'h007, 0, bits, dc, rc);
        check("o07_parity", {31'd0, bits[9]}, 32'd0);
        check("o07_done",   dc, 44);
        check("o07_ready",  rc, 45);

        // 7N2 CPB=2 0x55: two stop bits, 20-cycle frame
        run_frame(3, 9'h055, 0, bits, dc, rc);
        check("n2_bits", {22'd0, bits[9:0]}, 32'h3AA);
        check("n2_done", dc, 20);

        // Mid-frame data change and valid pulse must not disturb or queue anything
        run_frame(0, 9'h096, 15, bits, dc, rc);
        check("poke_bits", {22'd0, bits[9:0]}, 32'h32C);
        check("poke_done", dc, 40);
        repeat (20) @(negedge clk);
        check("poke_no_extra", {31'd0, busy_v[0]}, 32'd0);

        // Back-to-back: valid held, 0x01 then 0xFF; second start at done+2
        @(negedge clk);
        d0 = 8'h01;
        valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d0 = 8'hFF;
        dc = -1; start2 = -1;
        for (int c = 1; c <= 130; c++) begin
            if (done_v[0] && dc < 0) dc = c;
            if (dc > 0 && c > dc && !txd_v[0] && start2 < 0) begin
                start2 = c;
                valid_v[0] = 1'b0;
            end
            @(negedge clk);
        end
        valid_v[0] = 1'b0;
        check("b2b_done1",  dc, 40);
        check("b2b_start2", start2, 42);

        // Reset during data bit 3 (frame bit 4, cycles 17..20)
        @(negedge clk);
        d0 = 8'h5A;
        valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (17) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_txd",   {31'd0, txd_v[0]},   32'd1);
        check("rst_ready", {31'd0, ready_v[0]}, 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;

        run_frame(0, 9'h03C, 0, bits, dc, rc);
        check("post_rst_bits",  {22'd0, bits[9:0]}, 32'h278);
        check("post_rst_done",  dc, 40);
        check("post_rst_ready", rc, 41);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
